// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory controller.
//   SZ_*          access size encodings carried on req_size
//   dmem_state_t  controller FSM states
//   CNT_W         width of the latency down-counter (covers LATENCY up to 15)
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational big-endian lane steering for MIPS byte/half/word accesses.
// Ports:
//   size        in  2   access size (SZ_* encoding)
//   uns         in  1   zero-extend loads when set, sign-extend otherwise
//   lane        in  2   byte offset within the word (already aligned for half/word)
//   old_word    in  32  current array word
//   wdata       in  32  right-justified store data
//   store_word  out 32  old_word with the addressed lane(s) replaced
//   load_data   out 32  addressed lane(s) extracted and extended
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  lane,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] store_word,
  output logic [31:0] load_data
);

  // Big-endian: byte offset 0 lives in [31:24], so the bit offset is 8 * (3 - lane).
  logic [4:0]  byte_sh;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sh  = {~lane, 3'b000};
  assign byte_sel = old_word[byte_sh +: 8];
  assign half_sel = lane[1] ? old_word[15:0] : old_word[31:16];

  always_comb begin
    store_word = old_word;
    load_data  = '0;
    case (size)
      SZ_BYTE: begin
        store_word[byte_sh +: 8] = wdata[7:0];
        load_data = uns ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        if (lane[1]) store_word[15:0] = wdata[15:0];
        else         store_word[31:16] = wdata[15:0];
        load_data = uns ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        store_word = wdata;
        load_data  = old_word;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MIPS32 data memory with valid/ready request, fixed-latency response pulse,
// big-endian byte/half/word access and fault reporting.
// Build option: define DMEM_ALIGN_CHECK_EN to fault misaligned half/word accesses; when
// undefined the low address bits are forced to alignment instead.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake, accept on valid & ready
//   req_we, req_size, req_unsigned store flag, size encoding, load zero-extend
//   req_addr, req_wdata           byte address, right-justified store data
//   rsp_valid                     one-cycle response pulse, LATENCY cycles after accept
//   rsp_rdata, rsp_err            extended load data (0 for stores/faults), fault flag
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [CNT_W-1:0] CntInit = CNT_W'(LATENCY >= 2 ? LATENCY - 2 : 0);

  logic [31:0] mem [DEPTH_WORDS];

  dmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, uns_q;
  logic [1:0]       size_q;
  logic [31:0]      addr_q, wdata_q;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic             accept, enter_resp;
  logic             a_we, a_uns;
  logic [1:0]       a_size, lane;
  logic [31:0]      a_addr, a_wdata;
  logic [IDX_W-1:0] idx;
  logic             oob, acc_err;
  logic [31:0]      old_word, store_word, load_data;

  assign req_ready = !rst && (state_q == IDLE || state_q == RESP);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CntInit;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY=1 the array is accessed on the accept edge itself, so the live request
  // fields feed the access path; otherwise the latched copy does.
  assign a_we    = (state_q == WAIT) ? we_q    : req_we;
  assign a_uns   = (state_q == WAIT) ? uns_q   : req_unsigned;
  assign a_size  = (state_q == WAIT) ? size_q  : req_size;
  assign a_addr  = (state_q == WAIT) ? addr_q  : req_addr;
  assign a_wdata = (state_q == WAIT) ? wdata_q : req_wdata;

  assign idx = a_addr[IDX_W+1:2];
  assign oob = |a_addr[31:IDX_W+2];

  always_comb begin
    lane = a_addr[1:0];
    case (a_size)
      SZ_HALF: lane[0] = 1'b0;
      SZ_WORD: lane    = 2'b00;
      default: ;
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic misalign;
  assign misalign = ((a_size == SZ_HALF) && a_addr[0]) ||
                    ((a_size == SZ_WORD) && (a_addr[1:0] != 2'b00));
  assign acc_err  = (a_size == SZ_RSVD) || oob || misalign;
`else
  assign acc_err  = (a_size == SZ_RSVD) || oob;
`endif

  assign old_word = mem[idx];

  dmem_lane_align u_lane_align (
    .size       (a_size),
    .uns        (a_uns),
    .lane       (lane),
    .old_word   (old_word),
    .wdata      (a_wdata),
    .store_word (store_word),
    .load_data  (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || a_we) ? 32'h0 : load_data;
      end
    end
  end

  // Read-modify-write; reset suppresses a store that would otherwise land this edge.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && a_we && !acc_err) begin
      mem[idx] <= store_word;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign rsp_err   = rsp_valid && err_q;

endmodule
